// File: rtl/cpa_bist.sv
// cpa_bist: self-test driver/checker for a carry-propagate adder; golden (a+b) mod 2^N vs dut_y_i.
// Latency: vector k drives dut_a_o/dut_b_o in cycle k+1 after start, is checked in cycle k+1+LAT, and done_o pulses in cycle num_vec+LAT+1.
// Backpressure: none; one vector per cycle, no stalls; start_i ignored while busy. CPA_BIST_DIRECTED_EN prepends 3 directed vectors.
module cpa_bist #(
  parameter int unsigned N    = 64,
  parameter int unsigned LAT  = 1,
  parameter logic [63:0] SEED = 64'h0123456789ABCDEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [15:0]  num_vec_i,
  output logic [N-1:0] dut_a_o,
  output logic [N-1:0] dut_b_o,
  input  logic [N-1:0] dut_y_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic [15:0]  err_cnt_o,
  output logic [15:0]  first_err_idx_o
);

  // Galois mask for x^64+x^63+x^61+x^60+1 (right-shifting form).
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
  localparam int unsigned CW   = (LAT > 1) ? $clog2(LAT) : 1;

`ifdef CPA_BIST_DIRECTED_EN
  localparam logic [63:0] DIR0_A = 64'h1770_5351_EF64_0B95;
  localparam logic [63:0] DIR0_B = 64'h4D4E_FE8B_5D14_F84F;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [15:0]    num_vec_q;
  logic [15:0]    idx_q, idx_d;
  logic [63:0]    lfsr_q, lfsr_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]  drain_q, drain_d;
  logic           clr_run;
  logic           pass_q;
  logic [15:0]    err_cnt_q;
  logic [15:0]    first_err_q;

  // Golden pipeline: one entry per DUT latency cycle.
  logic           pipe_vld_q [LAT];
  logic [15:0]    pipe_idx_q [LAT];
  logic [N-1:0]   pipe_sum_q [LAT];

  // Candidate next vector and the LFSR state it is drawn from.
  logic [63:0]    nv_src;
  logic [63:0]    nv_rot;
  logic [63:0]    nv_step;
  logic [N-1:0]   nv_a, nv_b;
  logic           nv_rand;
  logic [N-1:0]   issue_sum;
  logic           mismatch;

  // Next vector: from SEED when a run is accepted, else from the running LFSR.
  always_comb begin
    nv_src  = (state_q == S_IDLE) ? SEED : lfsr_q;
    nv_rot  = {nv_src[31:0], nv_src[63:32]};
    nv_step = (nv_src >> 1) ^ (nv_src[0] ? TAPS : 64'd0);
    nv_a    = nv_src[N-1:0];
    nv_b    = nv_rot[N-1:0];
    nv_rand = 1'b1;
`ifdef CPA_BIST_DIRECTED_EN
    begin
      logic [15:0] dir_idx;
      dir_idx = (state_q == S_IDLE) ? 16'd0 : idx_q + 16'd1;
      if (dir_idx < 16'd3) begin
        nv_rand = 1'b0;
        case (dir_idx)
          16'd0:   begin nv_a = DIR0_A[N-1:0]; nv_b = DIR0_B[N-1:0]; end
          16'd1:   begin nv_a = '0;            nv_b = '0;            end
          default: begin nv_a = ONES[N-1:0];   nv_b = ONES[N-1:0];   end
        endcase
      end
    end
`endif
  end

  // FSM next state plus operand/index/LFSR updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    drain_d = drain_q;
    clr_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          clr_run = 1'b1;
          idx_d   = 16'd0;
          lfsr_d  = SEED;
          if (num_vec_i == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            a_d     = nv_a;
            b_d     = nv_b;
            lfsr_d  = nv_rand ? nv_step : SEED;
          end
        end
      end
      S_RUN: begin
        if (idx_q == num_vec_q - 16'd1) begin
          state_d = S_DRAIN;
          drain_d = CW'(LAT - 1);
        end else begin
          idx_d  = idx_q + 16'd1;
          a_d    = nv_a;
          b_d    = nv_b;
          lfsr_d = nv_rand ? nv_step : lfsr_q;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, operand and LFSR registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      num_vec_q <= 16'd0;
      idx_q     <= 16'd0;
      lfsr_q    <= SEED;
      a_q       <= '0;
      b_q       <= '0;
      drain_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      drain_q <= drain_d;
      if (clr_run) num_vec_q <= num_vec_i;
    end
  end

  assign issue_sum = a_q + b_q;

  // Golden shift register: a RUN-cycle vector is on the bus, its sum enters here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_vld_q[k] <= 1'b0;
        pipe_idx_q[k] <= 16'd0;
        pipe_sum_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= (state_q == S_RUN);
      pipe_idx_q[0] <= idx_q;
      pipe_sum_q[0] <= issue_sum;
      for (int k = 1; k < LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_idx_q[k] <= pipe_idx_q[k-1];
        pipe_sum_q[k] <= pipe_sum_q[k-1];
      end
    end
  end

  assign mismatch = pipe_vld_q[LAT-1] && (pipe_sum_q[LAT-1] != dut_y_i);

  // Result registers: saturating error count, first failing index, latched pass.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q   <= 16'd0;
      first_err_q <= 16'hFFFF;
      pass_q      <= 1'b0;
    end else if (clr_run) begin
      err_cnt_q   <= 16'd0;
      first_err_q <= 16'hFFFF;
      pass_q      <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0)    first_err_q <= pipe_idx_q[LAT-1];
      end
      if (state_q == S_DONE) pass_q <= (err_cnt_q == 16'd0);
    end
  end

  assign dut_a_o         = a_q;
  assign dut_b_o         = b_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  // The verdict is already visible in the DONE cycle, then held by pass_q.
  assign pass_o          = (state_q == S_DONE) ? (err_cnt_q == 16'd0) : pass_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_idx_o = first_err_q;

endmodule

// File: tb/tb_cpa_bist.sv
// Bench for cpa_bist: behavioural adder DUT with fault/stuck modes, queue-based vector model.
// Runs directed/random-length/fault/zero/mid-reset/saturation scenarios.
// Summary line reports comparisons made and failed.
`timescale 1ns/1ps
module tb_cpa_bist;
  localparam int          N    = 64;
  localparam int          LAT  = 1;
  localparam logic [63:0] SEED = 64'h0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [15:0]  num_vec_i = 16'd0;
  logic [N-1:0] dut_a_o, dut_b_o, y_q;
  logic         busy_o, done_o, pass_o;
  logic [15:0]  err_cnt_o, first_err_idx_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Adder under test model: registered sum, optional bit-0 fault or stuck-at-zero.
  bit           stuck = 1'b0;
  bit           fault_en = 1'b0;
  logic [N-1:0] fault_a = '0;

  always #5 clk = ~clk;

  always @(posedge clk)
    y_q <= stuck ? '0 : ((dut_a_o + dut_b_o) ^ N'(fault_en && (dut_a_o == fault_a)));

  cpa_bist #(.N(N), .LAT(LAT), .SEED(SEED)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .num_vec_i(num_vec_i),
    .dut_a_o(dut_a_o), .dut_b_o(dut_b_o), .dut_y_i(y_q),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o)
  );

  // Reference model: vector list of a run and expected verdict.
  logic [N-1:0] exp_a[$], exp_b[$], exp_sum[$];
  logic [15:0]  exp_err, exp_first;
  logic         exp_pass;

  // One step of the Galois LFSR for x^64+x^63+x^61+x^60+1.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ 64'hD800000000000000) : (s >> 1);
  endfunction

  function automatic void build_model(input int n);
    logic [63:0] s, a64, b64;
    exp_a.delete(); exp_b.delete(); exp_sum.delete();
    s = SEED;
    for (int k = 0; k < n; k++) begin
`ifdef CPA_BIST_DIRECTED_EN
      if (k == 0) begin a64 = 64'h17705351ef640b95; b64 = 64'h4d4efe8b5d14f84f; end
      else if (k == 1) begin a64 = 64'd0; b64 = 64'd0; end
      else if (k == 2) begin a64 = '1; b64 = '1; end
      else begin a64 = s; b64 = {s[31:0], s[63:32]}; s = lfsr_next(s); end
`else
      a64 = s; b64 = {s[31:0], s[63:32]}; s = lfsr_next(s);
`endif
      exp_a.push_back(a64[N-1:0]);
      exp_b.push_back(b64[N-1:0]);
      exp_sum.push_back(a64[N-1:0] + b64[N-1:0]);
    end
  endfunction

  // Verdict expected when the adder is stuck at zero or has one faulty vector (fault_k<0: none).
  function automatic void model_errors(input int n, input bit stuck_m, input int fault_k);
    int cnt;
    bit bad;
    cnt = 0;
    exp_first = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      bad = stuck_m ? (exp_sum[k] != '0) : (k == fault_k);
      if (bad) begin
        if (cnt == 0) exp_first = 16'(k);
        cnt++;
      end
    end
    exp_err  = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    exp_pass = (cnt == 0);
  endfunction

  // Observations captured by run_capture.
  int          obs_done_cyc, obs_done_cnt, obs_vec_bad, obs_busy_bad;
  logic        obs_busy_after, obs_pass, obs_pass_after;
  logic [15:0] obs_err, obs_first;

  // Starts a run of n vectors and records what the DUT does, cycle by cycle (bounded).
  task automatic run_capture(input int n, input int dup_cyc);
    obs_done_cyc = -1; obs_done_cnt = 0; obs_vec_bad = 0; obs_busy_bad = 0;
    obs_busy_after = 1'bx; obs_pass = 1'bx; obs_pass_after = 1'bx;
    obs_err = 16'hxxxx; obs_first = 16'hxxxx;
    @(negedge clk);
    start_i = 1'b1; num_vec_i = 16'(n);
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= n + LAT + 6; c++) begin
      if (c <= n)
        if (dut_a_o !== exp_a[c-1] || dut_b_o !== exp_b[c-1]) obs_vec_bad++;
      if (done_o === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c; obs_pass = pass_o; obs_err = err_cnt_o; obs_first = first_err_idx_o;
        end
      end else if (obs_done_cyc < 0 && busy_o !== 1'b1) begin
        obs_busy_bad++;
      end
      if (obs_done_cyc >= 0 && c == obs_done_cyc + 1) begin
        obs_busy_after = busy_o; obs_pass_after = pass_o;
        break;
      end
      if (c == dup_cyc) begin start_i = 1'b1; num_vec_i = 16'd3; end
      else start_i = 1'b0;
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (dut_a_o !== '0 || dut_b_o !== '0) begin tests_failed++; $display("FAIL reset_operands: got %0h/%0h expected 0/0", dut_a_o, dut_b_o); end
    tests_run++; if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got busy=%b done=%b pass=%b expected 0/0/0", busy_o, done_o, pass_o); end
    tests_run++; if (err_cnt_o !== 16'd0 || first_err_idx_o !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_counts: got err=%0h first=%0h expected 0/ffff", err_cnt_o, first_err_idx_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Three-vector run: directed pairs when enabled, else the first LFSR vectors.
  task automatic test_directed;
    build_model(3); model_errors(3, 1'b0, -1);
    run_capture(3, 0);
    tests_run++; if (obs_vec_bad !== 0) begin tests_failed++; $display("FAIL dir_vectors: got %0d bad vectors expected 0", obs_vec_bad); end
    tests_run++; if (obs_done_cyc !== 3 + LAT + 1) begin tests_failed++; $display("FAIL dir_done_cycle: got %0d expected %0d", obs_done_cyc, 3 + LAT + 1); end
    tests_run++; if (obs_pass !== 1'b1 || obs_err !== 16'd0) begin tests_failed++; $display("FAIL dir_verdict: got pass=%b err=%0h expected 1/0", obs_pass, obs_err); end
  endtask

  task automatic test_long;
    build_model(1000); model_errors(1000, 1'b0, -1);
    run_capture(1000, 0);
    tests_run++; if (obs_vec_bad !== 0) begin tests_failed++; $display("FAIL long_vectors: got %0d bad vectors expected 0", obs_vec_bad); end
    tests_run++; if (obs_done_cyc !== 1002) begin tests_failed++; $display("FAIL long_done_cycle: got %0d expected 1002", obs_done_cyc); end
    tests_run++; if (obs_pass !== 1'b1 || obs_first !== 16'hFFFF || obs_err !== 16'd0) begin tests_failed++; $display("FAIL long_verdict: got pass=%b first=%0h err=%0h expected 1/ffff/0", obs_pass, obs_first, obs_err); end
    tests_run++; if (obs_busy_bad !== 0 || obs_busy_after !== 1'b0 || obs_done_cnt !== 1) begin tests_failed++; $display("FAIL long_busy_done: got busy_gaps=%0d busy_after=%b done_cnt=%0d expected 0/0/1", obs_busy_bad, obs_busy_after, obs_done_cnt); end
  endtask

  task automatic test_fault;
    build_model(20); model_errors(20, 1'b0, 5);
    fault_a = exp_a[5]; fault_en = 1'b1;
    run_capture(20, 0);
    fault_en = 1'b0;
    tests_run++; if (obs_err !== 16'd1 || obs_first !== 16'd5) begin tests_failed++; $display("FAIL fault_counts: got err=%0h first=%0h expected 1/5", obs_err, obs_first); end
    tests_run++; if (obs_pass !== 1'b0 || obs_pass_after !== 1'b0) begin tests_failed++; $display("FAIL fault_pass: got %b/%b expected 0/0", obs_pass, obs_pass_after); end
  endtask

  // Random lengths with a random faulty vector, checked against the model verdict.
  task automatic test_random_runs;
    int n, fk;
    for (int r = 0; r < 4; r++) begin
      n  = int'($urandom_range(1, 60));
      fk = (r == 0) ? -1 : int'($urandom_range(0, n - 1));
      build_model(n); model_errors(n, 1'b0, fk);
      if (fk >= 0) begin fault_a = exp_a[fk]; fault_en = 1'b1; end
      run_capture(n, 0);
      fault_en = 1'b0;
      tests_run++; if (obs_vec_bad !== 0 || obs_done_cyc !== n + LAT + 1) begin tests_failed++; $display("FAIL rand_run%0d_timing: got bad=%0d done=%0d expected 0/%0d", r, obs_vec_bad, obs_done_cyc, n + LAT + 1); end
      tests_run++; if (obs_err !== exp_err || obs_first !== exp_first || obs_pass !== exp_pass) begin tests_failed++; $display("FAIL rand_run%0d_verdict: got err=%0h first=%0h pass=%b expected %0h/%0h/%b", r, obs_err, obs_first, obs_pass, exp_err, exp_first, exp_pass); end
    end
  endtask

  task automatic test_zero;
    logic [N-1:0] prev_a, prev_b;
    prev_a = dut_a_o; prev_b = dut_b_o;
    build_model(0);
    run_capture(0, 0);
    tests_run++; if (obs_done_cyc !== 1 || obs_pass !== 1'b1) begin tests_failed++; $display("FAIL zero_done: got cycle=%0d pass=%b expected 1/1", obs_done_cyc, obs_pass); end
    tests_run++; if (dut_a_o !== prev_a || dut_b_o !== prev_b) begin tests_failed++; $display("FAIL zero_operands: got %0h/%0h expected %0h/%0h", dut_a_o, dut_b_o, prev_a, prev_b); end
    tests_run++; if (obs_pass_after !== 1'b1) begin tests_failed++; $display("FAIL zero_pass_held: got %b expected 1", obs_pass_after); end
  endtask

  task automatic test_mid_reset;
    int done_seen;
    done_seen = 0;
    build_model(100);
    @(negedge clk); start_i = 1'b1; num_vec_i = 16'd100;
    @(negedge clk); start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++; if (dut_a_o !== '0 || dut_b_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_outputs: got a=%0h b=%0h busy=%b done=%b pass=%b expected all 0", dut_a_o, dut_b_o, busy_o, done_o, pass_o); end
    tests_run++; if (err_cnt_o !== 16'd0 || first_err_idx_o !== 16'hFFFF) begin tests_failed++; $display("FAIL midrst_counts: got %0h/%0h expected 0/ffff", err_cnt_o, first_err_idx_o); end
    repeat (3) begin @(negedge clk); if (done_o !== 1'b0) done_seen++; end
    rst_n = 1'b1;
    repeat (110) begin @(negedge clk); if (done_o !== 1'b0) done_seen++; end
    tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL midrst_no_done: got %0d done cycles expected 0", done_seen); end
    run_capture(100, 0);
    tests_run++; if (obs_vec_bad !== 0 || obs_done_cyc !== 100 + LAT + 1 || obs_pass !== 1'b1) begin tests_failed++; $display("FAIL midrst_rerun: got bad=%0d done=%0d pass=%b expected 0/%0d/1", obs_vec_bad, obs_done_cyc, 100 + LAT + 1, obs_pass); end
  endtask

  // Longest run with the adder stuck at zero and a stray start while busy.
  task automatic test_busy_start_saturate;
    build_model(65535); model_errors(65535, 1'b1, -1);
    stuck = 1'b1;
    run_capture(65535, 5);
    stuck = 1'b0;
    tests_run++; if (obs_done_cyc !== 65535 + LAT + 1 || obs_done_cnt !== 1) begin tests_failed++; $display("FAIL sat_done: got cycle=%0d count=%0d expected %0d/1", obs_done_cyc, obs_done_cnt, 65535 + LAT + 1); end
    tests_run++; if (obs_vec_bad !== 0) begin tests_failed++; $display("FAIL sat_vectors: got %0d bad expected 0", obs_vec_bad); end
    tests_run++; if (obs_err !== exp_err || obs_first !== exp_first) begin tests_failed++; $display("FAIL sat_counts: got err=%0h first=%0h expected %0h/%0h", obs_err, obs_first, exp_err, exp_first); end
    tests_run++; if (obs_pass !== 1'b0 || obs_busy_after !== 1'b0) begin tests_failed++; $display("FAIL sat_pass: got pass=%b busy_after=%b expected 0/0", obs_pass, obs_busy_after); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_long;
    test_fault;
    test_random_runs;
    test_zero;
    test_mid_reset;
    test_busy_start_saturate;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
